// File: rtl/sha2_block_seq.sv
// Collects 32 padded 16-bit words into a 512-bit block and sequences SHA-224/256 core start pulses.
// Tracks first/final block of a message and flags framing errors when in_last lands mid-block.
module sha2_block_seq #(
  parameter int CNT_WD = 16
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  input  logic              in_mode,
  output logic              in_ready,
  input  logic              abort,
  output logic              core_init,
  output logic              core_next,
  output logic              core_mode,
  output logic [511:0]      core_block,
  input  logic              core_ready,
  input  logic              core_digest_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_WD-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic [511:0]        block_q;
  logic                mode_q, mode_d;
  logic                first_q, first_d;
  logic                final_q, final_d;
  logic                err_q, err_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                wr_en;
  logic                accept;
  logic [8:0]          wr_base;

  // in_ready is gated by reset so the host sees it low while reset is held
  assign in_ready = ~puc_rst & ((state_q == S_IDLE) | (state_q == S_FILL));
  assign accept   = in_valid & in_ready;
  assign wr_base  = {idx_q, 4'b0000};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    first_d   = first_q;
    final_d   = final_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = in_mode;
          cnt_d   = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
          if (in_last) begin
            // a one-word message can never complete a block
            err_d = 1'b1;
            idx_d = 5'd0;
          end else begin
            wr_en   = 1'b1;
            idx_d   = idx_q + 5'd1;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          if (in_last && (idx_q != 5'd31)) begin
            err_d   = 1'b1;
            idx_d   = 5'd0;
            state_d = S_IDLE;
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'd31) begin
              final_d = in_last;
              state_d = S_START;
            end
          end
        end
      end
      S_START: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = ~first_q;
          cnt_d     = cnt_q + 1'b1;
          first_d   = 1'b0;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) begin
          if (final_q) begin
            done    = core_digest_valid;
            state_d = S_IDLE;
          end else begin
            idx_d   = 5'd0;
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      idx_d     = 5'd0;
      mode_d    = mode_q;
      first_d   = first_q;
      final_d   = final_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;
      core_init = 1'b0;
      core_next = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      block_q <= '0;
      mode_q  <= 1'b1;
      first_q <= 1'b0;
      final_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      final_q <= final_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (wr_en) block_q[wr_base +: 16] <= in_data;
    end
  end

  assign core_mode  = mode_q;
  assign core_block = block_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign blk_cnt    = cnt_q;

endmodule

// File: tb/tb_sha2_block_seq.sv
// Directed bench for sha2_block_seq with a behavioural hash-core latency model.
module tb_sha2_block_seq;

  localparam int LAT = 66;

  logic         mclk = 1'b0;
  logic         puc_rst;
  logic         in_valid, in_last, in_mode, in_ready, abort;
  logic [15:0]  in_data;
  logic         core_init, core_next, core_mode, core_ready, core_digest_valid;
  logic [511:0] core_block;
  logic         busy, done, err;
  logic [15:0]  blk_cnt;

  int total = 0;
  int bad   = 0;

  // core model
  logic rdy_q = 1'b1;
  logic dv_q  = 1'b0;
  logic hold  = 1'b0;
  int   lat_cnt = 0;

  // monitors
  int n_init = 0, n_next = 0, n_done = 0;
  int ready_bad = 0, overlap_bad = 0, width_bad = 0, stable_bad = 0, done_bad = 0;
  int init_at_next = 0;
  logic prev_pulse = 1'b0;
  logic snap_v = 1'b0;
  logic [511:0] snap;

  assign core_ready        = rdy_q & ~hold;
  assign core_digest_valid = dv_q;

  sha2_block_seq #(.CNT_WD(16)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .in_ready(in_ready), .abort(abort),
    .core_init(core_init), .core_next(core_next), .core_mode(core_mode),
    .core_block(core_block), .core_ready(core_ready),
    .core_digest_valid(core_digest_valid), .busy(busy), .done(done),
    .err(err), .blk_cnt(blk_cnt)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    if (core_init || core_next) begin
      rdy_q   <= 1'b0;
      dv_q    <= 1'b0;
      lat_cnt <= LAT;
    end else if (!rdy_q) begin
      if (lat_cnt == 0) begin
        rdy_q <= 1'b1;
        dv_q  <= 1'b1;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  always @(posedge mclk) begin
    if (core_init) n_init <= n_init + 1;
    if (core_next) begin
      n_next       <= n_next + 1;
      init_at_next <= n_init;
    end
    if (done) n_done <= n_done + 1;
    if ((core_init || core_next) && !core_ready) ready_bad <= ready_bad + 1;
    if (core_init && core_next) overlap_bad <= overlap_bad + 1;
    if (prev_pulse && (core_init || core_next)) width_bad <= width_bad + 1;
    if (done && !core_digest_valid) done_bad <= done_bad + 1;
    prev_pulse <= core_init | core_next;
    if (core_init || core_next) begin
      snap   <= core_block;
      snap_v <= 1'b1;
    end else if (in_ready) begin
      snap_v <= 1'b0;
    end else if (snap_v && (core_block !== snap)) begin
      stable_bad <= stable_bad + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [15:0] abc_word(input int k);
    logic [15:0] w;
    w = 16'h0000;
    if (k == 0)  w = 16'h6162;
    if (k == 1)  w = 16'h6380;
    if (k == 31) w = 16'h0018;
    return w;
  endfunction

  function automatic logic [15:0] pat_word(input int b, input int k);
    return 16'hA000 + 16'(b * 256) + 16'(k);
  endfunction

  // called just after a negedge; returns just after the negedge following acceptance
  task automatic send_word(input logic [15:0] d, input logic last, input logic mode);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_mode  = mode;
    while (!in_ready && t < 500) begin
      @(negedge mclk);
      t++;
    end
    total++;
    if (t >= 500) begin
      bad++;
      $display("FAIL send_word_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge mclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nblk, input logic mode, input bit use_abc);
    for (int b = 0; b < nblk; b++)
      for (int k = 0; k < 32; k++)
        send_word(use_abc ? abc_word(k) : pat_word(b, k), (b == nblk - 1) && (k == 31), mode);
  endtask

  task automatic wait_idle(input int maxc);
    int t;
    t = 0;
    while (busy && t < maxc) begin
      @(negedge mclk);
      t++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL wait_idle_timeout busy=%0b required=0", busy);
    end
  endtask

  task automatic test_reset;
    puc_rst = 1'b1;
    repeat (3) @(negedge mclk);
    total++;
    if ({in_ready, busy, done, err, core_init, core_next, core_mode} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_flags got=%b required=0000001",
               {in_ready, busy, done, err, core_init, core_next, core_mode});
    end
    total++;
    if (blk_cnt !== 16'd0 || core_block !== 512'd0) begin
      bad++;
      $display("FAIL reset_regs blk_cnt=%0d block_nonzero=%0b required 0/0", blk_cnt, |core_block);
    end
    puc_rst = 1'b0;
    @(negedge mclk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_abc;
    int i0, x0, d0;
    i0 = n_init; x0 = n_next; d0 = n_done;
    send_msg(1, 1'b1, 1'b1);
    wait_idle(300);
    @(negedge mclk);
    total++;
    if (n_init - i0 != 1 || n_next - x0 != 0) begin
      bad++;
      $display("FAIL abc_pulses init=%0d next=%0d required 1/0", n_init - i0, n_next - x0);
    end
    total++;
    if (blk_cnt !== 16'd1 || n_done - d0 != 1) begin
      bad++;
      $display("FAIL abc_count blk_cnt=%0d done=%0d required 1/1", blk_cnt, n_done - d0);
    end
    total++;
    if (core_block[15:0] !== 16'h6162 || core_block[31:16] !== 16'h6380 ||
        core_block[511:496] !== 16'h0018 || core_block[495:32] !== '0 || core_mode !== 1'b1) begin
      bad++;
      $display("FAIL abc_block w0=%h w1=%h w31=%h mode=%b required 6162/6380/0018/1",
               core_block[15:0], core_block[31:16], core_block[511:496], core_mode);
    end
  endtask

  task automatic test_two_block;
    int i0, x0, d0;
    i0 = n_init; x0 = n_next; d0 = n_done;
    send_msg(2, 1'b0, 1'b0);
    wait_idle(300);
    @(negedge mclk);
    total++;
    if (n_init - i0 != 1 || n_next - x0 != 1 || init_at_next != i0 + 1) begin
      bad++;
      $display("FAIL two_pulses init=%0d next=%0d init_before_next=%0d required 1/1/%0d",
               n_init - i0, n_next - x0, init_at_next, i0 + 1);
    end
    total++;
    if (blk_cnt !== 16'd2 || n_done - d0 != 1 || core_mode !== 1'b0) begin
      bad++;
      $display("FAIL two_count blk_cnt=%0d done=%0d mode=%b required 2/1/0", blk_cnt, n_done - d0, core_mode);
    end
    total++;
    if (core_block[15:0] !== 16'hA100 || core_block[511:496] !== 16'hA11F) begin
      bad++;
      $display("FAIL two_block w0=%h w31=%h required a100/a11f", core_block[15:0], core_block[511:496]);
    end
  endtask

  task automatic test_err;
    int i0, x0, d0;
    i0 = n_init; x0 = n_next; d0 = n_done;
    for (int k = 0; k <= 10; k++) send_word(pat_word(3, k), k == 10, 1'b1);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || n_init - i0 != 0 || n_next - x0 != 0) begin
      bad++;
      $display("FAIL err_set err=%b busy=%b pulses=%0d required 1/0/0", err, busy,
               (n_init - i0) + (n_next - x0));
    end
    for (int k = 0; k < 32; k++) begin
      send_word(abc_word(k), k == 31, 1'b1);
      if (k == 5) begin
        in_last = 1'b1;
        repeat (3) @(negedge mclk);
        in_last = 1'b0;
      end
    end
    wait_idle(300);
    @(negedge mclk);
    total++;
    if (err !== 1'b0 || n_done - d0 != 1 || n_init - i0 != 1 || blk_cnt !== 16'd1) begin
      bad++;
      $display("FAIL err_clear err=%b done=%0d init=%0d blk_cnt=%0d required 0/1/1/1",
               err, n_done - d0, n_init - i0, blk_cnt);
    end
  endtask

  task automatic test_abort;
    int i0, x0, d0;
    i0 = n_init; x0 = n_next; d0 = n_done;
    for (int k = 0; k < 32; k++) send_word(pat_word(0, k), 1'b0, 1'b1);
    repeat (5) @(negedge mclk);
    abort = 1'b1;
    @(negedge mclk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b required=0", busy);
    end
    repeat (120) @(negedge mclk);
    total++;
    if (n_init - i0 != 1 || n_next - x0 != 0 || n_done - d0 != 0 || blk_cnt !== 16'd1) begin
      bad++;
      $display("FAIL abort_after init=%0d next=%0d done=%0d blk_cnt=%0d required 1/0/0/1",
               n_init - i0, n_next - x0, n_done - d0, blk_cnt);
    end
  endtask

  task automatic test_stall;
    int i0, x0, errs;
    i0 = n_init; x0 = n_next; errs = 0;
    hold = 1'b1;
    send_msg(1, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || n_init != i0 || n_next != x0) errs++;
      @(negedge mclk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_hold bad_cycles=%0d required=0", errs);
    end
    hold = 1'b0;
    wait_idle(300);
    @(negedge mclk);
    total++;
    if (n_init - i0 != 1 || n_next - x0 != 0) begin
      bad++;
      $display("FAIL stall_release init=%0d next=%0d required 1/0", n_init - i0, n_next - x0);
    end
  endtask

  task automatic test_reset_mid;
    int i0, x0;
    i0 = n_init; x0 = n_next;
    for (int k = 0; k < 17; k++) send_word(pat_word(5, k), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = pat_word(5, 17);
    puc_rst  = 1'b1;
    @(negedge mclk);
    total++;
    if ({in_ready, busy, done, err, core_init, core_next, core_mode} !== 7'b0000001 ||
        blk_cnt !== 16'd0 || core_block !== 512'd0) begin
      bad++;
      $display("FAIL rstmid_state flags=%b blk_cnt=%0d block_nonzero=%0b required 0000001/0/0",
               {in_ready, busy, done, err, core_init, core_next, core_mode}, blk_cnt, |core_block);
    end
    in_valid = 1'b0;
    puc_rst  = 1'b0;
    @(negedge mclk);
    send_msg(1, 1'b0, 1'b1);
    wait_idle(300);
    @(negedge mclk);
    total++;
    if (n_init - i0 != 1 || n_next - x0 != 0 || blk_cnt !== 16'd1 || core_mode !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_next init=%0d next=%0d blk_cnt=%0d mode=%b required 1/0/1/0",
               n_init - i0, n_next - x0, blk_cnt, core_mode);
    end
  endtask

  task automatic test_protocol;
    total++;
    if (ready_bad != 0 || overlap_bad != 0 || width_bad != 0 || stable_bad != 0 || done_bad != 0) begin
      bad++;
      $display("FAIL protocol ready=%0d overlap=%0d width=%0d stable=%0d done=%0d required all 0",
               ready_bad, overlap_bad, width_bad, stable_bad, done_bad);
    end
  endtask

  initial begin
    puc_rst  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mode  = 1'b0;
    in_data  = 16'h0000;
    abort    = 1'b0;
    @(negedge mclk);
    test_reset;
    test_abc;
    test_two_block;
    test_err;
    test_abort;
    test_stall;
    test_reset_mid;
    test_protocol;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha2_block_seq.md
SHA2_BLOCK_SEQ -- requirements
Module: sha2_block_seq

Interface
REQ-001 SHALL have parameter CNT_WD, default 16, width of the processed-block counter.
REQ-002 SHALL have clock mclk, input, 1, all state on rising edge.
REQ-003 SHALL have reset puc_rst, input, 1, asynchronous, active-high.
REQ-004 SHALL have in_valid, input, 1, host word valid.
REQ-005 SHALL have in_data, input, 16, message word, already padded by host.
REQ-006 SHALL have in_last, input, 1, marks final word of final block.
REQ-007 SHALL have in_mode, input, 1, digest mode (1=SHA-256, 0=SHA-224), sampled on first word of a message.
REQ-008 SHALL have in_ready, output, 1, sequencer accepts word this cycle.
REQ-009 SHALL have abort, input, 1, synchronous return to IDLE.
REQ-010 SHALL have core_init, core_next, output, 1 each, single-cycle start pulses to the hash core.
REQ-011 SHALL have core_mode, output, 1, latched message mode.
REQ-012 SHALL have core_block, output, 512, assembled block.
REQ-013 SHALL have core_ready, input, 1, core idle.
REQ-014 SHALL have core_digest_valid, input, 1, core digest valid.
REQ-015 SHALL have busy, output, 1, message in progress.
REQ-016 SHALL have done, output, 1, one-cycle pulse when final digest valid.
REQ-017 SHALL have err, output, 1, sticky framing error.
REQ-018 SHALL have blk_cnt, output, CNT_WD, blocks issued for current message.

Function
REQ-019 SHALL implement states IDLE, FILL, START, WAIT, SETTLE.
REQ-020 Word handshake SHALL complete when in_valid & in_ready in the same cycle; in_ready=1 only in IDLE and FILL.
REQ-021 Accepted word k (0..31) SHALL be written to core_block[k*16 +: 16]; 5-bit word index increments per accepted word and wraps 31->0.
REQ-022 IDLE: accepted word SHALL latch in_mode to core_mode, clear blk_cnt and err, set first-block flag, go to FILL.
REQ-023 FILL: on accepting word index 31, SHALL go to START; in_last is recorded as final flag.
REQ-024 in_last on word index !=31 SHALL set err, discard the partial block, clear index, go to IDLE without starting the core.
REQ-025 START: when core_ready=1, SHALL pulse core_init if first-block flag set, else core_next, exactly one cycle; increment blk_cnt (wraps at 2^CNT_WD); clear first-block flag; go to SETTLE. If core_ready=0, hold in START.
REQ-026 SETTLE: SHALL stay exactly one cycle (core ready deasserts), then go to WAIT.
REQ-027 WAIT: on core_ready=1, if final flag SHALL go to IDLE and pulse done when core_digest_valid=1 that cycle; else return to FILL with index 0.
REQ-028 core_block SHALL remain stable from START entry until WAIT exit.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 core_init and core_next SHALL never be high simultaneously nor for more than one cycle.
REQ-031 abort SHALL have priority over all transitions: next state IDLE, index 0, no core pulse that cycle; blk_cnt and err hold.
REQ-032 in_last with in_valid=0 SHALL be ignored.

Reset
REQ-033 On puc_rst: state IDLE, index 0, core_block 0, core_init 0, core_next 0, core_mode 1, busy 0, done 0, err 0, blk_cnt 0, in_ready 0 while reset asserted, 1 the first cycle after release.
REQ-034 Reset mid-message SHALL discard all progress with no core pulse issued.

Verification
REQ-035 Single block "abc" padded (32 words, in_last on word 31), mode 1, core model ready after 66 cycles -> one core_init, no core_next, blk_cnt=1, done pulse once, digest BA7816BF...F20015AD.
REQ-036 Two-block message (64 words) -> core_init then core_next, each only after core_ready=1, blk_cnt=2, block words stable during WAIT, one done.
REQ-037 in_last on word 10 -> err=1, no core pulse, state IDLE; next valid message clears err.
REQ-038 abort asserted in WAIT of block 1 of 2 -> busy=0 next cycle, no further core pulse, no done.
REQ-039 core_ready held low 20 cycles in START -> in_ready=0, no pulse until ready, then exactly one pulse.
REQ-040 puc_rst asserted during FILL word 17 -> all outputs at reset values; following message starts with core_init and blk_cnt=1.
